// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state encodings shared by the alu_seq slice
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_EQ   = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_LTS  = 4'b1000;
  localparam logic [3:0] OP_LTU  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1100;
  localparam logic [3:0] OP_NE   = 4'b1101;
  localparam logic [3:0] OP_BSEL = 4'b1110;
  localparam logic [3:0] OP_ILL  = 4'b1111;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative LSB-first shift-add multiplier; accumulator is 2*WIDTH wide under ALU_SEQ_OVF_EN
module alu_seq_mul #(
  parameter int WIDTH = 64,
`ifdef ALU_SEQ_OVF_EN
  localparam int AW = 2 * WIDTH
`else
  localparam int AW = WIDTH
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [AW-1:0]    prod
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] a_r;
  logic [AW-1:0]    b_r;
  logic [AW-1:0]    acc;
  logic [SHW-1:0]   cnt;
  // prod includes the bit being processed this cycle so the final step yields the full product
  assign prod = acc + (a_r[0] ? b_r : '0);
  assign done = run && cnt == SHW'(WIDTH - 1);
  // load operands on start, then retire one multiplier bit per cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      a_r <= a;
      b_r <= AW'(b);
      acc <= '0;
      cnt <= '0;
    end else if (run) begin
      acc <= prod;
      a_r <= a_r >> 1;
      b_r <= b_r << 1;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked registered ALU with iterative multiply; ALU_SEQ_OVF_EN adds the ovf output
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int SHW = $clog2(WIDTH),
`ifdef ALU_SEQ_OVF_EN
  localparam int AW = 2 * WIDTH
`else
  localparam int AW = WIDTH
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       aluctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             zero,
`ifdef ALU_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             err
);
  logic [0:0]       state;
  logic [WIDTH-1:0] res;
  logic [AW-1:0]    mprod;
  logic             mdone;
  logic             accept;
  assign in_ready = state == ST_IDLE && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .CLK(CLK),
    .RST(RST),
    .start(accept && aluctrl == OP_MUL),
    .run(state == ST_MUL),
    .a(A),
    .b(B),
    .done(mdone),
    .prod(mprod)
  );
  // single-cycle result; mul and illegal produce 0 here
  always_comb begin
    res = '0;
    case (aluctrl)
      OP_ADD:  res = A + B;
      OP_SUB:  res = A - B;
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_XNOR: res = ~(A ^ B);
      OP_EQ:   res = WIDTH'(A == B);
      OP_NE:   res = WIDTH'(A != B);
      OP_LTS:  res = WIDTH'($signed(A) < $signed(B));
      OP_LTU:  res = WIDTH'(A < B);
      OP_SLL:  res = A << shamt;
      OP_SRA:  res = WIDTH'($signed(A) >>> shamt);
      OP_SRL:  res = A >> shamt;
      OP_BSEL: res = WIDTH'(A[B[SHW-1:0]]);
      default: res = '0;
    endcase
  end
`ifdef ALU_SEQ_OVF_EN
  logic res_ovf;
  assign res_ovf = aluctrl == OP_ADD ? (A[WIDTH-1] == B[WIDTH-1] && res[WIDTH-1] != A[WIDTH-1]) :
                   aluctrl == OP_SUB ? (A[WIDTH-1] != B[WIDTH-1] && res[WIDTH-1] != A[WIDTH-1]) : 1'b0;
`endif
  // FSM and output register: mul completion, new accepts, or draining the held result
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      Z         <= '0;
      zero      <= 1'b1;
      err       <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (mdone) begin
      state     <= ST_IDLE;
      out_valid <= 1'b1;
      Z         <= mprod[WIDTH-1:0];
      zero      <= mprod[WIDTH-1:0] == '0;
      err       <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf       <= |mprod[AW-1:WIDTH];
`endif
    end else if (accept && aluctrl == OP_MUL) begin
      state     <= ST_MUL;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      Z         <= res;
      zero      <= res == '0;
      err       <= aluctrl == OP_ILL;
`ifdef ALU_SEQ_OVF_EN
      ovf       <= res_ovf;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the processor's 64-bit registered ALU, used in the NetFPGA datapath.
- Single-cycle ops: same registered-output latency as before, plus valid/ready flow control, status flags and an illegal-op error.
- Adds an iterative shift-add multiplier (multi-cycle, FSM-controlled).
- Adds signed compare and arithmetic shift.

Parameters:
WIDTH, 64, operand/result width; power of two, 8..64.
SHW, $clog2(WIDTH), shift-amount width; localparam, derived, not overridable.

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  reset; synchronous, active-high
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept an op this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
shamt  in  SHW  shift amount
aluctrl  in  4  opcode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
Z  out  WIDTH  result
zero  out  1  Z == 0
err  out  1  illegal opcode flagged with this result

Behaviour:
- Reset: on RST=1 at a clock edge:
  - state=IDLE, out_valid=0, Z=0, zero=1, err=0, iteration counter=0.
  - Reset mid-multiply abandons the operation; no result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The op is accepted when in_valid && in_ready.
- Opcodes:
  - 0000 add, 0001 sub (both mod 2^WIDTH)
  - 0010 and, 0011 or, 0100 xor, 0101 xnor
  - 0110 eq, 1101 ne, 1000 lt signed, 1001 lt unsigned: result {0..0,bit}
  - 1010 sll A<<shamt, 1011 sra (sign fill), 1100 srl (zero fill)
  - 1110 bit-select: Z[0]=A[B[SHW-1:0]], upper bits 0
  - 0111 mul: low WIDTH bits of A*B, unsigned
  - 1111 illegal: Z=0, err=1
- Single-cycle ops: accepted at edge N; Z/out_valid updated at the same edge, visible cycle N+1 (latency 1). Back-to-back throughput is 1/cycle while out_ready=1.
- FSM:
  - IDLE: a mul accept latches A, B, clears the accumulator, counter=0, goes to MUL.
  - MUL: one multiplier bit per cycle (LSB first): acc += B_shifted if A bit set; counter++. On counter==WIDTH-1, write Z, set out_valid, go to IDLE.
  - Mul result is visible WIDTH cycles after the accept edge. in_ready=0 throughout MUL.
- Output hold: while out_valid && !out_ready, Z/zero/err/out_valid are held stable and no op is accepted. Simultaneous out_ready and new accept: the new result replaces the old in the same edge.
- zero and err are registered together with Z. err clears on the next accepted legal op.
- No overflow reporting unless the macro below is defined. Carries wrap silently.

Optional Feature:
Macro ALU_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit), registered with Z.
  - Set for signed overflow on add/sub (operand signs equal and result sign differs, sub using ~B sign).
  - Set for mul if any product bit at WIDTH and above is nonzero; the accumulator is widened to 2*WIDTH to detect this.
  - Reset value 0; 0 for all other ops.
- Undefined: no ovf port, WIDTH-wide accumulator, behaviour otherwise identical.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_ADD..OP_ILL), FSM state encoding (ST_IDLE, ST_MUL).
- One sub-module, alu_seq_mul: iterative multiplier with start/done, counter and accumulator, parametrised by WIDTH.
- Combinational op decode stays in alu_seq.

Test Plan:
- WIDTH=64, RST held 2 cycles then released -> out_valid=0, Z=0, zero=1, err=0, in_ready=1.
- add: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> next cycle Z=0, zero=1, out_valid=1. With ALU_SEQ_OVF_EN: ovf=0.
- add with ALU_SEQ_OVF_EN: A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> Z=64'h8000_0000_0000_0000, ovf=1.
- sra vs srl: A=64'h8000_0000_0000_0000, shamt=4 -> sra Z=64'hF800_0000_0000_0000; srl Z=64'h0800_0000_0000_0000.
- lt signed vs unsigned: A=-1, B=1 -> op 1000 Z=1; op 1001 Z=0.
- mul, WIDTH=16: A=16'd300, B=16'd7 -> in_ready low 16 cycles; Z=16'd2100 appears 16 cycles after accept.
- Backpressure: hold out_ready=0 after an add result -> Z stable, in_ready=0 for 5 cycles. Then out_ready=1 with a pending op 1111 -> next result Z=0, err=1.
- RST asserted at cycle 5 of a mul -> out_valid never rises for that op; in_ready=1 the cycle after reset.
